// File: rtl/data_path_if.sv
// Control and observation bundle between a control unit and the single-bus datapath.
interface data_path_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             R1in, R2in, R3in, R4in;
  logic             R2out, R3out;
  logic             MDRin, MDRout, MD_read;
  logic             MARin, PCin, IRin, Yin;
  logic             Zlowin, Zlowout, IncPC;
  logic [WIDTH-1:0] Mdatain;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] R1_q, R2_q, R3_q, R4_q;
  logic [WIDTH-1:0] PC_q, IR_q, MAR_q, MDR_q, Y_q;
  logic [WIDTH-1:0] ZHI_q, ZLO_q;

  modport master (
    output R1in, R2in, R3in, R4in, R2out, R3out,
    output MDRin, MDRout, MD_read, MARin, PCin, IRin, Yin,
    output Zlowin, Zlowout, IncPC, Mdatain,
    input  BusMuxOut, R1_q, R2_q, R3_q, R4_q,
    input  PC_q, IR_q, MAR_q, MDR_q, Y_q, ZHI_q, ZLO_q
  );

  modport slave (
    input  R1in, R2in, R3in, R4in, R2out, R3out,
    input  MDRin, MDRout, MD_read, MARin, PCin, IRin, Yin,
    input  Zlowin, Zlowout, IncPC, Mdatain,
    output BusMuxOut, R1_q, R2_q, R3_q, R4_q,
    output PC_q, IR_q, MAR_q, MDR_q, Y_q, ZHI_q, ZLO_q
  );
endinterface

// File: rtl/data_path.sv
// Single-bus CPU datapath: general registers, PC/IR/MAR/MDR/Y, 64-bit Z and a combinational ALU.
module data_path #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clock,
  input  logic       clear,
  data_path_if.slave dp
);
  localparam int unsigned ZW  = 2 * WIDTH;
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r1_q, r2_q, r3_q, r4_q, pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q;
  logic [WIDTH-1:0] r1_d, r2_d, r3_d, r4_d, pc_d, ir_d, mar_d, mdr_d, y_d, zhi_d, zlo_d;

  logic [WIDTH-1:0] bus_c;
  logic [WIDTH-1:0] sum_c, diff_c, neg_c, pc_inc_c;
  logic [ZW-1:0]    prod_c;
  logic [ZW-1:0]    alu_c;

  // Bus source selection; ZLO wins over MDR, then R2, then R3; idle bus reads zero.
  always_comb begin
    bus_c = '0;
    if (dp.Zlowout)     bus_c = zlo_q;
    else if (dp.MDRout) bus_c = mdr_q;
    else if (dp.R2out)  bus_c = r2_q;
    else if (dp.R3out)  bus_c = r3_q;
  end

  // Arithmetic terms kept at bus width so they wrap rather than carry into ZHI.
  always_comb begin
    sum_c    = y_q + bus_c;
    diff_c   = y_q - bus_c;
    neg_c    = '0 - bus_c;
    pc_inc_c = pc_q + WIDTH'(1);
    prod_c   = $signed({{WIDTH{y_q[WIDTH-1]}}, y_q}) * $signed({{WIDTH{bus_c[WIDTH-1]}}, bus_c});
  end

  // ALU: A = Y, B = bus, opcode from IR[3:0]; IncPC overrides the opcode.
  always_comb begin
    alu_c = '0;
    if (dp.IncPC) begin
      alu_c = {{WIDTH{1'b0}}, pc_inc_c};
    end else begin
      case (ir_q[3:0])
        4'd0:    alu_c = {{WIDTH{1'b0}}, sum_c};
        4'd1:    alu_c = {{WIDTH{1'b0}}, diff_c};
        4'd2:    alu_c = {{WIDTH{1'b0}}, y_q & bus_c};
        4'd3:    alu_c = {{WIDTH{1'b0}}, y_q | bus_c};
        4'd4:    alu_c = {{WIDTH{1'b0}}, y_q >> bus_c[SHW-1:0]};
        4'd5:    alu_c = {{WIDTH{1'b0}}, y_q << bus_c[SHW-1:0]};
        4'd6:    alu_c = prod_c;
        4'd7:    alu_c = {{WIDTH{1'b0}}, neg_c};
        4'd8:    alu_c = {{WIDTH{1'b0}}, ~bus_c};
        default: alu_c = '0;
      endcase
    end
  end

  // Next-state for every register: hold unless its load enable is high.
  always_comb begin
    r1_d  = r1_q;
    r2_d  = r2_q;
    r3_d  = r3_q;
    r4_d  = r4_q;
    pc_d  = pc_q;
    ir_d  = ir_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    y_d   = y_q;
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    if (dp.R1in)  r1_d  = bus_c;
    if (dp.R2in)  r2_d  = bus_c;
    if (dp.R3in)  r3_d  = bus_c;
    if (dp.R4in)  r4_d  = bus_c;
    if (dp.PCin)  pc_d  = bus_c;
    if (dp.IRin)  ir_d  = bus_c;
    if (dp.MARin) mar_d = bus_c;
    if (dp.Yin)   y_d   = bus_c;
    if (dp.MDRin) mdr_d = dp.MD_read ? dp.Mdatain : bus_c;
    if (dp.Zlowin) begin
      zhi_d = alu_c[ZW-1:WIDTH];
      zlo_d = alu_c[WIDTH-1:0];
    end
  end

  // Register bank; clear zeroes everything asynchronously.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end else begin
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
    end
  end

  assign dp.BusMuxOut = bus_c;
  assign dp.R1_q      = r1_q;
  assign dp.R2_q      = r2_q;
  assign dp.R3_q      = r3_q;
  assign dp.R4_q      = r4_q;
  assign dp.PC_q      = pc_q;
  assign dp.IR_q      = ir_q;
  assign dp.MAR_q     = mar_q;
  assign dp.MDR_q     = mdr_q;
  assign dp.Y_q       = y_q;
  assign dp.ZHI_q     = zhi_q;
  assign dp.ZLO_q     = zlo_q;
endmodule

// File: tb/tb_data_path.sv
// Directed and randomized bench for data_path against an arithmetic reference model.
module tb_data_path;
  localparam int unsigned W = 32;

  // control word bit positions
  localparam int unsigned B_R1IN = 0, B_R2IN = 1, B_R3IN = 2, B_R4IN = 3;
  localparam int unsigned B_R2OUT = 4, B_R3OUT = 5, B_MDRIN = 6, B_MDROUT = 7;
  localparam int unsigned B_MDREAD = 8, B_MARIN = 9, B_PCIN = 10, B_IRIN = 11;
  localparam int unsigned B_YIN = 12, B_ZIN = 13, B_ZOUT = 14, B_INCPC = 15;

  localparam logic [15:0] R1IN = 16'(1 << B_R1IN), R2IN = 16'(1 << B_R2IN);
  localparam logic [15:0] R3IN = 16'(1 << B_R3IN), R4IN = 16'(1 << B_R4IN);
  localparam logic [15:0] R2OUT = 16'(1 << B_R2OUT), R3OUT = 16'(1 << B_R3OUT);
  localparam logic [15:0] MDRIN = 16'(1 << B_MDRIN), MDROUT = 16'(1 << B_MDROUT);
  localparam logic [15:0] MDREAD = 16'(1 << B_MDREAD), MARIN = 16'(1 << B_MARIN);
  localparam logic [15:0] PCIN = 16'(1 << B_PCIN), IRIN = 16'(1 << B_IRIN);
  localparam logic [15:0] YIN = 16'(1 << B_YIN), ZIN = 16'(1 << B_ZIN);
  localparam logic [15:0] ZOUT = 16'(1 << B_ZOUT), INCPC = 16'(1 << B_INCPC);

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;

  // reference model state
  logic [W-1:0] m_r1, m_r2, m_r3, m_r4, m_pc, m_ir, m_mar, m_mdr, m_y, m_zhi, m_zlo;

  data_path_if #(.WIDTH(W)) dpi ();

  data_path #(.WIDTH(W)) dut (
    .clock (clk),
    .clear (clr),
    .dp    (dpi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".R1"},  dpi.R1_q,  m_r1);
    check({pfx, ".R2"},  dpi.R2_q,  m_r2);
    check({pfx, ".R3"},  dpi.R3_q,  m_r3);
    check({pfx, ".R4"},  dpi.R4_q,  m_r4);
    check({pfx, ".PC"},  dpi.PC_q,  m_pc);
    check({pfx, ".IR"},  dpi.IR_q,  m_ir);
    check({pfx, ".MAR"}, dpi.MAR_q, m_mar);
    check({pfx, ".MDR"}, dpi.MDR_q, m_mdr);
    check({pfx, ".Y"},   dpi.Y_q,   m_y);
    check({pfx, ".ZHI"}, dpi.ZHI_q, m_zhi);
    check({pfx, ".ZLO"}, dpi.ZLO_q, m_zlo);
  endtask

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_r3 = '0; m_r4 = '0; m_pc = '0; m_ir = '0;
    m_mar = '0; m_mdr = '0; m_y = '0; m_zhi = '0; m_zlo = '0;
  endtask

  // ALU behaviour from the opcode table, using plain integer arithmetic
  function automatic logic [2*W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic inc,
                                             input logic [W-1:0] pc);
    longint          sa;
    longint          sb;
    logic [W-1:0]    r;
    logic [4:0]      sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    if (inc) begin
      r = pc + 32'd1;
      return {32'd0, r};
    end
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a >> sh;
      4'd5: r = a << sh;
      4'd6: return 64'(sa * sb);
      4'd7: r = 32'd0 - b;
      4'd8: r = ~b;
      default: r = '0;
    endcase
    return {32'd0, r};
  endfunction

  task automatic drive(input logic [15:0] c, input logic [W-1:0] md);
    dpi.R1in    = c[B_R1IN];
    dpi.R2in    = c[B_R2IN];
    dpi.R3in    = c[B_R3IN];
    dpi.R4in    = c[B_R4IN];
    dpi.R2out   = c[B_R2OUT];
    dpi.R3out   = c[B_R3OUT];
    dpi.MDRin   = c[B_MDRIN];
    dpi.MDRout  = c[B_MDROUT];
    dpi.MD_read = c[B_MDREAD];
    dpi.MARin   = c[B_MARIN];
    dpi.PCin    = c[B_PCIN];
    dpi.IRin    = c[B_IRIN];
    dpi.Yin     = c[B_YIN];
    dpi.Zlowin  = c[B_ZIN];
    dpi.Zlowout = c[B_ZOUT];
    dpi.IncPC   = c[B_INCPC];
    dpi.Mdatain = md;
  endtask

  // One transfer: drive mid-cycle, check the bus, clock it, check every register.
  task automatic step(input string tag, input logic [15:0] c, input logic [W-1:0] md);
    logic [W-1:0]   b;
    logic [2*W-1:0] z;
    @(negedge clk);
    drive(c, md);
    #1;
    if (c[B_ZOUT])        b = m_zlo;
    else if (c[B_MDROUT]) b = m_mdr;
    else if (c[B_R2OUT])  b = m_r2;
    else if (c[B_R3OUT])  b = m_r3;
    else                  b = '0;
    check({tag, ".bus"}, dpi.BusMuxOut, b);
    z = ref_alu(m_ir[3:0], m_y, b, c[B_INCPC], m_pc);
    @(posedge clk);
    #1;
    if (c[B_R1IN])  m_r1  = b;
    if (c[B_R2IN])  m_r2  = b;
    if (c[B_R3IN])  m_r3  = b;
    if (c[B_R4IN])  m_r4  = b;
    if (c[B_PCIN])  m_pc  = b;
    if (c[B_IRIN])  m_ir  = b;
    if (c[B_MARIN]) m_mar = b;
    if (c[B_YIN])   m_y   = b;
    if (c[B_MDRIN]) m_mdr = c[B_MDREAD] ? md : b;
    if (c[B_ZIN]) begin
      m_zhi = z[2*W-1:W];
      m_zlo = z[W-1:0];
    end
    check_all(tag);
  endtask

  initial begin
    logic [15:0] rc;
    vectors     = 0;
    miscompares = 0;
    clr         = 1'b1;
    drive(16'h0000, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    clr = 1'b0;

    // register loads through MDR
    step("ld_mdr12", MDREAD | MDRIN, 32'h12);
    check("mdr12", dpi.MDR_q, 32'h12);
    step("ld_r2", MDROUT | R2IN, '0);
    check("r2_12", dpi.R2_q, 32'h12);
    step("ld_mdr0d", MDREAD | MDRIN, 32'hD);
    step("ld_r3", MDROUT | R3IN, '0);
    check("r3_0d", dpi.R3_q, 32'hD);
    step("ld_mdr18", MDREAD | MDRIN, 32'h18);
    step("ld_r1", MDROUT | R1IN, '0);
    check("r1_18", dpi.R1_q, 32'h18);

    // MUL instruction T0..T5
    step("t0", INCPC | ZIN, '0);
    step("t1", ZOUT | PCIN | MDREAD | MDRIN, 32'h6);
    step("t2", MDROUT | IRIN, '0);
    step("t3", R2OUT | YIN, '0);
    step("t4", R3OUT | ZIN, '0);
    step("t5", ZOUT | R1IN, '0);
    check("mul_pc", dpi.PC_q, 32'h1);
    check("mul_ir", dpi.IR_q, 32'h6);
    check("mul_y", dpi.Y_q, 32'h12);
    check("mul_zlo", dpi.ZLO_q, 32'hEA);
    check("mul_zhi", dpi.ZHI_q, 32'h0);
    check("mul_r1", dpi.R1_q, 32'hEA);
    check("mul_r2", dpi.R2_q, 32'h12);
    check("mul_r3", dpi.R3_q, 32'hD);

    // signed multiply -2 * 3
    step("smul_a", MDREAD | MDRIN, 32'hFFFF_FFFE);
    step("smul_y", MDROUT | YIN, '0);
    step("smul_b", MDREAD | MDRIN, 32'h3);
    step("smul_z", MDROUT | ZIN, '0);
    check("smul_zhi", dpi.ZHI_q, 32'hFFFF_FFFF);
    check("smul_zlo", dpi.ZLO_q, 32'hFFFF_FFFA);

    // PC increment wraps to zero
    step("wrap_md", MDREAD | MDRIN, 32'hFFFF_FFFF);
    step("wrap_pc", MDROUT | PCIN, '0);
    step("wrap_inc", INCPC | ZIN, '0);
    check("wrap_zlo", dpi.ZLO_q, 32'h0);
    check("wrap_zhi", dpi.ZHI_q, 32'h0);

    // bus priority and idle bus
    step("pri_md", MDREAD | MDRIN, 32'h40);
    step("pri_pc", MDROUT | PCIN, '0);
    step("pri_inc", INCPC | ZIN, '0);
    step("pri_zr2", ZOUT | R2OUT | R4IN, '0);
    check("pri_r4", dpi.R4_q, 32'h41);
    step("idle_r4", R4IN, '0);
    check("idle_r4z", dpi.R4_q, 32'h0);

    // asynchronous clear between edges with live registers
    step("pre_clr", MDROUT | R4IN | MARIN | YIN, '0);
    @(negedge clk);
    drive(16'h0000, '0);
    clr = 1'b1;
    model_reset();
    #1;
    check_all("clr_async");
    #2;
    clr = 1'b0;

    // randomized transfers
    for (int i = 0; i < 400; i++) begin
      rc = 16'($urandom);
      if (($urandom % 4) != 0) rc[B_INCPC] = 1'b0;
      step("rand", rc, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus CPU datapath with general registers R1–R4, PC, IR, MAR, MDR, Y, a 64-bit Z (ZHI/ZLO) and a combinational ALU.
- A control unit or testbench FSM drives one-hot register load enables and bus-drive selects.
- Each register transfer or ALU step completes on one rising clock edge.
- Sits below the control unit; memory data arrives on Mdatain.

Parameters:
- WIDTH, 32, data/bus width. Z is 2*WIDTH.

Ports:
- clock  in  1  system clock; all registers load on the rising edge.
- clear  in  1  asynchronous active-high reset; zeroes every register.
- R1in, R2in, R3in, R4in  in  1 each  load Rn from the bus.
- R2out, R3out  in  1 each  drive R2 / R3 onto the bus.
- MDRin  in  1  load MDR from the MDR input mux.
- MDRout  in  1  drive MDR onto the bus.
- MD_read  in  1  MDR input mux select: 1 = Mdatain, 0 = bus.
- MARin  in  1  load MAR from the bus.
- PCin  in  1  load PC from the bus.
- IRin  in  1  load IR from the bus.
- Yin  in  1  load Y from the bus.
- Zlowin  in  1  load the 64-bit Z (ZHI and ZLO) from the ALU result.
- Zlowout  in  1  drive ZLO onto the bus.
- IncPC  in  1  force the ALU to compute PC+1.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value, for observation.
- R1_q, R2_q, R3_q, R4_q, PC_q, IR_q, MAR_q, MDR_q, Y_q  out  32 each  register contents, for observation.
- ZHI_q, ZLO_q  out  32 each  Z halves.

Behaviour:
- Reset: clear=1 asynchronously forces every register (R1–R4, PC, IR, MAR, MDR, Y, ZHI, ZLO) to 0, overriding any load enable. Applies mid-operation too.
- Bus: combinational selection from the asserted out-signal.
  - Fixed priority when more than one is asserted: Zlowout > MDRout > R2out > R3out.
  - No out-signal asserted: bus = 0.
- Loads: on a rising clock edge with clear=0, each register whose *in* enable is high captures its source.
  - R1–R4, MAR, PC, IR and Y capture the bus.
  - MDR captures (MD_read ? Mdatain : bus).
  - Z captures the ALU result; ZLO = low 32 bits, ZHI = high 32 bits.
  - Registers with their enable low hold their value.
  - A register may be loaded and driven in the same cycle: it drives its old value and captures the new value on the edge.
- ALU: combinational. A = Y, B = bus. Operation code op = IR[3:0].
  - IncPC=1 overrides op: result = {32'b0, PC+1}, with 32-bit wrap (0xFFFFFFFF -> 0).
  - 0 ADD: A+B, wrap, ZHI=0.
  - 1 SUB: A-B, wrap, ZHI=0.
  - 2 AND.
  - 3 OR.
  - 4 SHR: logical shift right, A >> B[4:0].
  - 5 SHL: A << B[4:0].
  - 6 MUL: signed 32x32 -> 64 product; ZHI = upper half, ZLO = lower half.
  - 7 NEG: -B.
  - 8 NOT: ~B.
  - 9–15: result 0.
  - For every op except MUL, ZHI = 0.
- Latency: one clock edge per transfer. Output ports reflect register values immediately after the edge; BusMuxOut is purely combinational.
- Instruction sequence MUL (IR=6):
  - T0: IncPC, Zlowin → Z = PC+1.
  - T1: Zlowout, PCin, MD_read, MDRin → PC = Z, MDR = Mdatain.
  - T2: MDRout, IRin → IR = MDR.
  - T3: R2out, Yin → Y = R2.
  - T4: R3out, Zlowin → Z = Y*R3.
  - T5: Zlowout, R1in → R1 = ZLO.

Test Plan:
- Reset: drive registers to nonzero values, assert clear between clock edges → all *_q outputs read 0 immediately, before the next clock edge.
- Register load: Mdatain=0x12, MD_read=1 + MDRin for one edge → MDR=0x12. Then MDRout + R2in → R2=0x12. Repeat with 0xD into R3 and 0x18 into R1.
- MUL sequence T0–T5 with Mdatain=0x6 at T1 (R2=0x12, R3=0xD, starting from reset) → PC=1, IR=6, Y=0x12, ZLO=0xEA, ZHI=0, R1=0xEA; R2 and R3 unchanged.
- Signed MUL: Y=0xFFFFFFFE (−2), bus=3, op 6 → ZHI=0xFFFFFFFF, ZLO=0xFFFFFFFA.
- IncPC wrap: PC=0xFFFFFFFF, IncPC + Zlowin → ZLO=0, ZHI=0.
- Bus priority and idle: Zlowout and R2out asserted together → bus = ZLO. No out-signals asserted → bus = 0, and an R4in load gives R4=0.
